// File: rtl/dac_output_switch_pkg.sv
// Shared types and constants for the DAC output switch.
package dac_output_switch_pkg;

  localparam int          LANE_W    = 16;
  localparam logic [15:0] GAIN_FULL = 16'h7FFF;
  localparam logic [1:0]  SEL_MUTE  = 2'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

endpackage

// File: rtl/lane_gain_mult.sv
// One output lane: applies a Q1.15 gain to a signed sample and registers the
// result. Full-scale gain bypasses the multiplier so samples pass bit-exact.
module lane_gain_mult
  import dac_output_switch_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic [LANE_W-1:0] sample,
  input  logic [15:0]       gain,
  output logic [LANE_W-1:0] result
);

  logic signed [31:0] product;

  // Signed 16x16 product; gain is 0..32767 so its sign bit is always clear.
  always_comb begin
    product = $signed(sample) * $signed(gain);
  end

  // Stage-2 register: bypass at full gain, otherwise floor-scaled product.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (gain == GAIN_FULL) begin
      result <= sample;
    end else begin
      result <= 16'(product >>> 15);
    end
  end

endmodule

// File: rtl/dac_output_switch.sv
// Glitch-free source selector for the DAC lanes: fades the current stream to
// zero, swaps the source at zero gain, then fades the new stream back in.
module dac_output_switch
  import dac_output_switch_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int RAMP_STEP      = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [1:0]                       sel_req,
  input  logic [LANE_W*NUMBER_OF_LINE-1:0] dac1_data,
  input  logic [LANE_W*NUMBER_OF_LINE-1:0] dac2_data,
  input  logic [LANE_W*NUMBER_OF_LINE-1:0] dac3_data,
  output logic [LANE_W*NUMBER_OF_LINE-1:0] dac_data,
  output logic [1:0]                       active_sel,
  output logic [15:0]                      gain,
  output logic                             busy
);

  localparam int          BUS_W     = LANE_W * NUMBER_OF_LINE;
  localparam logic [16:0] STEP      = 17'(RAMP_STEP);
  localparam logic [16:0] FULL_EXT  = {1'b0, GAIN_FULL};

  logic [1:0]       rst_sync;
  logic             rst_int;
  state_t           state;
  logic [1:0]       pend_sel;
  logic [16:0]      gain_sum;
  logic [15:0]      gain_up;
  logic [15:0]      gain_dn;
  logic [BUS_W-1:0] s1_data;
  logic [15:0]      s1_gain;

  // Reset synchronizer: asserts immediately, releases two clocks after reset drops.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  // Saturating next-gain values for both ramp directions.
  // NOTE: every variable gets a value on every path through this block, so no
  // latch is inferred.
  always_comb begin
    gain_sum = {1'b0, gain} + STEP;
    gain_up  = (gain_sum > FULL_EXT) ? GAIN_FULL : gain_sum[15:0];
    gain_dn  = ({1'b0, gain} > STEP) ? (gain - STEP[15:0]) : 16'd0;
  end

  // Selection FSM with registered gain, routing and busy flag.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state      <= RUN;
      active_sel <= SEL_MUTE;
      pend_sel   <= SEL_MUTE;
      gain       <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (sel_req != active_sel) begin
            pend_sel <= sel_req;
            state    <= FADE_OUT;
            busy     <= 1'b1;
          end
        end
        FADE_OUT: begin
          // Latest request wins until the source is actually swapped.
          pend_sel <= sel_req;
          gain     <= gain_dn;
          if (gain_dn == 16'd0) begin
            state <= SWITCH;
          end
        end
        SWITCH: begin
          active_sel <= pend_sel;
          if (pend_sel == SEL_MUTE) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            state <= FADE_IN;
          end
        end
        FADE_IN: begin
          gain <= gain_up;
          if (gain_up == GAIN_FULL) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the selected stream (mute gives zero) with its gain.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      s1_data <= '0;
      s1_gain <= '0;
    end else begin
      case (active_sel)
        2'd1:    s1_data <= dac1_data;
        2'd2:    s1_data <= dac2_data;
        2'd3:    s1_data <= dac3_data;
        default: s1_data <= '0;
      endcase
      s1_gain <= gain;
    end
  end

  // Stage 2: one gain multiplier per lane.
  for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : gen_lane
    lane_gain_mult u_lane (
      .clock  (clock),
      .rst    (rst_int),
      .sample (s1_data[LANE_W*k +: LANE_W]),
      .gain   (s1_gain),
      .result (dac_data[LANE_W*k +: LANE_W])
    );
  end

endmodule

// File: tb/tb_dac_output_switch.sv
// Self-checking bench for dac_output_switch: a default-ramp instance for the
// long fades and a single-step-ramp instance for cycle-exact table vectors.
module tb_dac_output_switch;

  localparam int N = 8;
  localparam int W = 16 * N;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  // Default ramp (256) instance.
  logic [1:0]   sel_s = 2'd0;
  logic [W-1:0] d1s = '0, d2s = '0, d3s = '0;
  logic [W-1:0] out_s;
  logic [1:0]   asel_s;
  logic [15:0]  gain_s;
  logic         busy_s;

  // One-cycle ramp (32767) instance.
  logic [1:0]   sel_f = 2'd0;
  logic [W-1:0] d1f = '0, d2f = '0, d3f = '0;
  logic [W-1:0] out_f;
  logic [1:0]   asel_f;
  logic [15:0]  gain_f;
  logic         busy_f;

  int n_checks = 0;
  int n_fail   = 0;

  dac_output_switch #(.NUMBER_OF_LINE(N), .RAMP_STEP(256)) u_slow (
    .clock(clock), .reset(reset), .sel_req(sel_s),
    .dac1_data(d1s), .dac2_data(d2s), .dac3_data(d3s),
    .dac_data(out_s), .active_sel(asel_s), .gain(gain_s), .busy(busy_s)
  );

  dac_output_switch #(.NUMBER_OF_LINE(N), .RAMP_STEP(32767)) u_fast (
    .clock(clock), .reset(reset), .sel_req(sel_f),
    .dac1_data(d1f), .dac2_data(d2f), .dac3_data(d3f),
    .dac_data(out_f), .active_sel(asel_f), .gain(gain_f), .busy(busy_f)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  exp_sel;
    logic [15:0] exp_gain;
    logic        exp_busy;
    logic [15:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    vec_t         vecs [17];
    logic [W-1:0] prev, cur;
    logic [15:0]  exp_g, exp_o, gain_at_change, prev_gain;
    logic [1:0]   last_sel;
    int           cnt, changes, mono_bad, rise, saw3;
    logic signed [15:0] prev_lane;

    // sel_req applied before each edge, expected outputs after it.
    vecs[0]  = '{2'd1, 2'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[1]  = '{2'd1, 2'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{2'd1, 2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{2'd1, 2'd1, 16'h7FFF, 1'b0, 16'h0000};
    vecs[4]  = '{2'd1, 2'd1, 16'h7FFF, 1'b0, 16'h0000};
    vecs[5]  = '{2'd1, 2'd1, 16'h7FFF, 1'b0, 16'h4000};
    vecs[6]  = '{2'd2, 2'd1, 16'h7FFF, 1'b1, 16'h4000};
    vecs[7]  = '{2'd2, 2'd1, 16'h0000, 1'b1, 16'h4000};
    vecs[8]  = '{2'd2, 2'd2, 16'h0000, 1'b1, 16'h4000};
    vecs[9]  = '{2'd2, 2'd2, 16'h7FFF, 1'b0, 16'h0000};
    vecs[10] = '{2'd2, 2'd2, 16'h7FFF, 1'b0, 16'h0000};
    vecs[11] = '{2'd2, 2'd2, 16'h7FFF, 1'b0, 16'hFC18};
    vecs[12] = '{2'd0, 2'd2, 16'h7FFF, 1'b1, 16'hFC18};
    vecs[13] = '{2'd0, 2'd2, 16'h0000, 1'b1, 16'hFC18};
    vecs[14] = '{2'd0, 2'd0, 16'h0000, 1'b0, 16'hFC18};
    vecs[15] = '{2'd0, 2'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[16] = '{2'd0, 2'd0, 16'h0000, 1'b0, 16'h0000};

    // Reset state, both instances.
    step();
    check("rst slow data", out_s, '0);
    check("rst slow gain", gain_s, '0);
    check("rst slow sel", asel_s, '0);
    check("rst slow busy", busy_s, '0);
    check("rst fast data", out_f, '0);
    check("rst fast busy", busy_f, '0);
    reset = 1'b0;
    step();
    step();

    // Table: one-cycle ramps on the fast instance.
    d1f = rep(16'h4000);
    d2f = rep(16'hFC18);
    d3f = rep(16'h1234);
    for (int i = 0; i < 17; i++) begin
      sel_f = vecs[i].sel;
      step();
      check($sformatf("table[%0d] sel", i), asel_f, vecs[i].exp_sel);
      check($sformatf("table[%0d] gain", i), gain_f, vecs[i].exp_gain);
      check($sformatf("table[%0d] busy", i), busy_f, vecs[i].exp_busy);
      check($sformatf("table[%0d] data", i), out_f, rep(vecs[i].exp_out));
    end

    // Bit-exact bypass of a random stream at full gain, 2-cycle latency.
    sel_f = 2'd3;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (busy_f && cnt < 20);
    check("bypass settle timeout", (cnt < 20), 1'b1);
    check("bypass gain", gain_f, 16'h7FFF);
    check("bypass sel", asel_f, 2'd3);
    step();
    step();
    prev = d3f;
    for (int i = 0; i < 20; i++) begin
      cur = {$urandom, $urandom, $urandom, $urandom};
      d3f = cur;
      step();
      check($sformatf("bypass[%0d]", i), out_f, prev);
      prev = cur;
    end

    // A: fade-in from mute to dac1 = 0x4000 with 256 steps.
    do_reset();
    d1s = rep(16'h4000);
    sel_s = 2'd1;
    step();
    check("a fade_out busy", busy_s, 1'b1);
    check("a fade_out gain", gain_s, '0);
    check("a fade_out sel", asel_s, 2'd0);
    step();
    check("a switch sel", asel_s, 2'd0);
    check("a switch busy", busy_s, 1'b1);
    step();
    check("a fade_in sel", asel_s, 2'd1);
    check("a fade_in gain", gain_s, '0);
    for (int k = 1; k <= 130; k++) begin
      step();
      exp_g = (k >= 128) ? 16'h7FFF : 16'(256 * k);
      check($sformatf("a gain k=%0d", k), gain_s, exp_g);
      check($sformatf("a busy k=%0d", k), busy_s, (k < 128));
      if (k < 2)        exp_o = 16'h0000;
      else if (k <= 129) exp_o = 16'(128 * (k - 2));
      else              exp_o = 16'h4000;
      check($sformatf("a data k=%0d", k), out_s, rep(exp_o));
    end

    // B: dac1 = -32768 to dac2 = 1000, monotonic, single swap at zero gain.
    d1s = rep(16'h8000);
    step();
    step();
    check("b start data", out_s, rep(16'h8000));
    d2s = rep(16'h03E8);
    sel_s = 2'd2;
    cnt = 0;
    changes = 0;
    mono_bad = 0;
    gain_at_change = 16'hFFFF;
    last_sel = asel_s;
    prev_lane = $signed(out_s[15:0]);
    do begin
      step();
      cnt++;
      if ($signed(out_s[15:0]) < prev_lane) mono_bad++;
      prev_lane = $signed(out_s[15:0]);
      if (asel_s != last_sel) begin
        changes++;
        gain_at_change = gain_s;
      end
      last_sel = asel_s;
    end while (busy_s && cnt < 600);
    check("b cycles", cnt, 258);
    check("b sel changes", changes, 1);
    check("b gain at swap", gain_at_change, 16'h0000);
    check("b monotonic", mono_bad, 0);
    check("b final sel", asel_s, 2'd2);
    check("b final gain", gain_s, 16'h7FFF);
    step();
    step();
    check("b final data", out_s, rep(16'h03E8));

    // C: during fade-out request 3 then mute; ends muted, no fade-in.
    sel_s = 2'd3;
    for (int i = 0; i < 10; i++) step();
    sel_s = 2'd0;
    cnt = 0;
    rise = 0;
    saw3 = 0;
    prev_gain = gain_s;
    do begin
      step();
      cnt++;
      if (gain_s > prev_gain) rise++;
      if (asel_s == 2'd3) saw3++;
      prev_gain = gain_s;
    end while (busy_s && cnt < 400);
    check("c timeout", (cnt < 400), 1'b1);
    check("c sel", asel_s, 2'd0);
    check("c gain", gain_s, 16'h0000);
    check("c no rise", rise, 0);
    check("c never 3", saw3, 0);
    step();
    step();
    step();
    check("c data", out_s, '0);
    check("c still idle", busy_s, 1'b0);
    check("c gain held", gain_s, 16'h0000);

    // D: request dac1 while fading in toward dac3.
    sel_s = 2'd3;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (asel_s != 2'd3 && cnt < 20);
    check("d reach 3", asel_s, 2'd3);
    for (int i = 0; i < 5; i++) step();
    sel_s = 2'd1;
    cnt = 0;
    while (busy_s && cnt < 400) begin
      step();
      cnt++;
    end
    check("d fade_in done sel", asel_s, 2'd3);
    check("d fade_in done gain", gain_s, 16'h7FFF);
    step();
    check("d refade busy", busy_s, 1'b1);
    check("d refade gain", gain_s, 16'h7FFF);
    check("d refade sel", asel_s, 2'd3);
    step();
    check("d first step", gain_s, 16'h7EFF);

    // E: asynchronous reset in the middle of a fade-in.
    do_reset();
    d1s = rep(16'h4000);
    sel_s = 2'd1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (gain_s != 16'd8192 && cnt < 200);
    check("e gain 8192", gain_s, 16'd8192);
    check("e data before", out_s, rep(16'h0F00));
    #2;
    reset = 1'b1;
    #1;
    check("e async data", out_s, '0);
    check("e async gain", gain_s, '0);
    check("e async sel", asel_s, '0);
    check("e async busy", busy_s, '0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("e restart busy", busy_s, 1'b1);
    check("e restart gain", gain_s, '0);
    step();
    check("e switch sel", asel_s, 2'd0);
    step();
    check("e fade_in sel", asel_s, 2'd1);
    step();
    check("e fade_in gain", gain_s, 16'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
